// File: rtl/fwd_pkg.sv
// Shared select and hold-state encodings for the EX-stage operand forwarding logic.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_HELD = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_HELD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/fwd_src_slice.sv
// One EX source operand: MEM > HELD > WB select, zero-cycle combinational output.
// Captures the WB value while EX is stalled so it outlives the retiring writer.
module fwd_src_slice
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] ex_src,
    input  logic              mem_RegWr,
    input  logic              mem_MemToReg,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic [DATA_W-1:0] mem_aluOut,
    input  logic              wr_RegWr,
    input  logic [REG_AW-1:0] wr_wsel,
    input  logic [DATA_W-1:0] writeback,
    output logic              override,
    output logic [DATA_W-1:0] new_rdat
);

    hold_state_t       state;
    logic [DATA_W-1:0] hold_data;
    fwd_sel_t          sel;
    logic              src_nz;
    logic              mem_hit;
    logic              wb_hit;

    // A load sitting in MEM has no data yet, so it never forwards from there.
    assign src_nz  = (ex_src != '0);
    assign mem_hit = src_nz && mem_RegWr && !mem_MemToReg && (mem_wsel == ex_src);
    assign wb_hit  = src_nz && wr_RegWr && (wr_wsel == ex_src);

    always_comb begin
        sel = FWD_NONE;
        if (src_nz) begin
            if (mem_hit)
                sel = FWD_MEM;
            else if (state == HOLD_HELD)
                sel = FWD_HELD;
            else if (wb_hit)
                sel = FWD_WB;
        end
    end

    always_comb begin
        new_rdat = '0;
        case (sel)
            FWD_MEM:  new_rdat = mem_aluOut;
            FWD_HELD: new_rdat = hold_data;
            FWD_WB:   new_rdat = writeback;
            default:  new_rdat = '0;
        endcase
    end

    assign override = (sel != FWD_NONE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HOLD_EMPTY;
            hold_data <= '0;
        end else if (flush || !ex_stall) begin
            state <= HOLD_EMPTY;
        end else if (state == HOLD_EMPTY && !mem_hit && wb_hit) begin
            state     <= HOLD_HELD;
            hold_data <= writeback;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use stall detect and saturating event counters.
// Forwarding and lu_stall are combinational (zero latency); lu_stall is masked during ex_stall/flush.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] ex_src [NSRC],
    input  logic [REG_AW-1:0] id_src [NSRC],
    input  logic              ex_RegWr,
    input  logic              ex_MemRead,
    input  logic [REG_AW-1:0] ex_wsel,
    input  logic              mem_RegWr,
    input  logic              mem_MemToReg,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic [DATA_W-1:0] mem_aluOut,
    input  logic              wr_RegWr,
    input  logic [REG_AW-1:0] wr_wsel,
    input  logic [DATA_W-1:0] writeback,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              override [NSRC],
    output logic [DATA_W-1:0] new_rdat [NSRC],
    output logic              lu_stall,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  lu_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             id_hit;
    logic [CNT_W:0]   fwd_inc;
    logic [CNT_W:0]   fwd_sum;
    logic [CNT_W-1:0] fwd_next;
    logic [CNT_W-1:0] lu_next;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_src_slice #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_slice (
            .clk          (CLK),
            .rst          (RST),
            .ex_stall     (ex_stall),
            .flush        (flush),
            .ex_src       (ex_src[i]),
            .mem_RegWr    (mem_RegWr),
            .mem_MemToReg (mem_MemToReg),
            .mem_wsel     (mem_wsel),
            .mem_aluOut   (mem_aluOut),
            .wr_RegWr     (wr_RegWr),
            .wr_wsel      (wr_wsel),
            .writeback    (writeback),
            .override     (override[i]),
            .new_rdat     (new_rdat[i])
        );
    end

    always_comb begin
        id_hit = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (id_src[j] == ex_wsel)
                id_hit = 1'b1;
        end
    end

    // A frozen pipeline already keeps the load's consumer out of EX.
    assign lu_stall = ex_MemRead && ex_RegWr && (ex_wsel != '0) && id_hit
                      && !ex_stall && !flush && !RST;

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NSRC; i++)
            fwd_inc = fwd_inc + {{CNT_W{1'b0}}, override[i]};
    end

    assign fwd_sum  = {1'b0, fwd_cnt} + fwd_inc;
    assign fwd_next = fwd_sum[CNT_W] ? CNT_MAX : fwd_sum[CNT_W-1:0];
    assign lu_next  = (lu_cnt == CNT_MAX) ? lu_cnt : lu_cnt + CNT_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd_cnt <= '0;
            lu_cnt  <= '0;
        end else begin
            if (!ex_stall)
                fwd_cnt <= fwd_next;
            if (lu_stall)
                lu_cnt <= lu_next;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit with narrow counters so saturation is reachable.
module tb_fwd_hazard_unit;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] ex_src [NS];
    logic [AW-1:0] id_src [NS];
    logic          ex_RegWr, ex_MemRead;
    logic [AW-1:0] ex_wsel;
    logic          mem_RegWr, mem_MemToReg;
    logic [AW-1:0] mem_wsel;
    logic [DW-1:0] mem_aluOut;
    logic          wr_RegWr;
    logic [AW-1:0] wr_wsel;
    logic [DW-1:0] writeback;
    logic          ex_stall, flush;
    logic          override [NS];
    logic [DW-1:0] new_rdat [NS];
    logic          lu_stall;
    logic [CW-1:0] fwd_cnt, lu_cnt;

    fwd_hazard_unit #(
        .DATA_W (DW),
        .REG_AW (AW),
        .NSRC   (NS),
        .CNT_W  (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ex_src       (ex_src),
        .id_src       (id_src),
        .ex_RegWr     (ex_RegWr),
        .ex_MemRead   (ex_MemRead),
        .ex_wsel      (ex_wsel),
        .mem_RegWr    (mem_RegWr),
        .mem_MemToReg (mem_MemToReg),
        .mem_wsel     (mem_wsel),
        .mem_aluOut   (mem_aluOut),
        .wr_RegWr     (wr_RegWr),
        .wr_wsel      (wr_wsel),
        .writeback    (writeback),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .override     (override),
        .new_rdat     (new_rdat),
        .lu_stall     (lu_stall),
        .fwd_cnt      (fwd_cnt),
        .lu_cnt       (lu_cnt)
    );

    always #5 CLK = ~CLK;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_q [$];

    logic          m_held [NS];
    logic [DW-1:0] m_hdat [NS];
    int            m_fwd, m_lu;
    logic          e_ov [NS];
    logic [DW-1:0] e_rd [NS];
    logic          e_lu;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic mem_hit_f(input logic [AW-1:0] s);
        return (s != 0) && mem_RegWr && !mem_MemToReg && (mem_wsel == s);
    endfunction

    function automatic logic wb_hit_f(input logic [AW-1:0] s);
        return (s != 0) && wr_RegWr && (wr_wsel == s);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_held[i] = 1'b0;
            m_hdat[i] = '0;
        end
        m_fwd = 0;
        m_lu  = 0;
    endtask

    task automatic model_comb();
        for (int i = 0; i < NS; i++) begin
            e_ov[i] = 1'b0;
            e_rd[i] = '0;
            if (ex_src[i] != 0) begin
                if (mem_hit_f(ex_src[i])) begin
                    e_ov[i] = 1'b1; e_rd[i] = mem_aluOut;
                end else if (m_held[i]) begin
                    e_ov[i] = 1'b1; e_rd[i] = m_hdat[i];
                end else if (wb_hit_f(ex_src[i])) begin
                    e_ov[i] = 1'b1; e_rd[i] = writeback;
                end
            end
            if (RST) e_ov[i] = 1'b0;
        end
        e_lu = !RST && !ex_stall && !flush && ex_MemRead && ex_RegWr && ex_wsel != 0
               && (ex_wsel == id_src[0] || ex_wsel == id_src[1]);
    endtask

    task automatic model_edge();
        if (RST) begin
            model_clear();
        end else begin
            if (!ex_stall) begin
                m_fwd = m_fwd + int'(e_ov[0]) + int'(e_ov[1]);
                if (m_fwd > CMAX) m_fwd = CMAX;
            end
            if (e_lu && m_lu < CMAX) m_lu = m_lu + 1;
            for (int i = 0; i < NS; i++) begin
                if (flush || !ex_stall) begin
                    m_held[i] = 1'b0;
                end else if (!m_held[i] && !mem_hit_f(ex_src[i]) && wb_hit_f(ex_src[i])) begin
                    m_held[i] = 1'b1;
                    m_hdat[i] = writeback;
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        model_comb();
        exp_q.push_back(32'(e_ov[0])); exp_q.push_back(e_rd[0]);
        exp_q.push_back(32'(e_ov[1])); exp_q.push_back(e_rd[1]);
        exp_q.push_back(32'(e_lu));
        check("override0", 32'(override[0]), exp_q.pop_front());
        check("new_rdat0", new_rdat[0],       exp_q.pop_front());
        check("override1", 32'(override[1]), exp_q.pop_front());
        check("new_rdat1", new_rdat[1],       exp_q.pop_front());
        check("lu_stall",  32'(lu_stall),     exp_q.pop_front());
        model_edge();
        exp_q.push_back(32'(m_fwd));
        exp_q.push_back(32'(m_lu));
        @(posedge CLK);
        #1;
        check("fwd_cnt", 32'(fwd_cnt), exp_q.pop_front());
        check("lu_cnt",  32'(lu_cnt),  exp_q.pop_front());
        @(negedge CLK);
    endtask

    task automatic async_reset();
        #2 RST = 1'b1;
        #1;
        model_clear();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        check("arst_fwd_cnt",   32'(fwd_cnt),     exp_q.pop_front());
        check("arst_lu_cnt",    32'(lu_cnt),      exp_q.pop_front());
        check("arst_override0", 32'(override[0]), exp_q.pop_front());
        check("arst_override1", 32'(override[1]), exp_q.pop_front());
    endtask

    task automatic idle();
        for (int i = 0; i < NS; i++) begin
            ex_src[i] = '0;
            id_src[i] = '0;
        end
        ex_RegWr = 0; ex_MemRead = 0; ex_wsel = '0;
        mem_RegWr = 0; mem_MemToReg = 0; mem_wsel = '0; mem_aluOut = '0;
        wr_RegWr = 0; wr_wsel = '0; writeback = '0;
        ex_stall = 0; flush = 0;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        model_clear();
        @(negedge CLK);
        cycle();
        RST = 1'b0;

        // MEM beats WB; source 1 on r0 stays silent
        ex_src[0] = 5'd3; mem_RegWr = 1; mem_wsel = 5'd3; mem_aluOut = 32'hA5;
        wr_RegWr = 1; wr_wsel = 5'd3; writeback = 32'h11;
        cycle();
        ex_src[0] = 5'd0; mem_wsel = 5'd0; wr_wsel = 5'd0; ex_RegWr = 1; ex_wsel = 5'd0;
        cycle();
        // WB-only forward, then a MEM load defers to WB
        idle();
        ex_src[1] = 5'd5; wr_RegWr = 1; wr_wsel = 5'd5; writeback = 32'h55;
        cycle();
        mem_RegWr = 1; mem_MemToReg = 1; mem_wsel = 5'd5; mem_aluOut = 32'hDEAD;
        cycle();

        // Hold across a 3-cycle stall while WB moves on
        idle();
        ex_src[0] = 5'd7; wr_RegWr = 1; wr_wsel = 5'd7; writeback = 32'h1234; ex_stall = 1;
        cycle();
        wr_wsel = 5'd9; writeback = 32'hFFFF;
        cycle();
        cycle();
        ex_stall = 0;
        cycle();
        cycle();

        // Flush drops a held value even while stalled
        wr_wsel = 5'd7; writeback = 32'h77; ex_stall = 1;
        cycle();
        wr_wsel = 5'd9;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        cycle();

        // Load-use detection and its masking
        idle();
        ex_MemRead = 1; ex_RegWr = 1; ex_wsel = 5'd4; id_src[1] = 5'd4;
        cycle();
        ex_stall = 1;
        cycle();
        ex_stall = 0; flush = 1;
        cycle();
        flush = 0; ex_wsel = 5'd0; id_src[1] = 5'd0;
        cycle();
        ex_wsel = 5'd4; id_src[0] = 5'd4; id_src[1] = 5'd2; ex_RegWr = 0;
        cycle();

        // Async reset mid-run, then drive both counters into saturation
        idle();
        async_reset();
        cycle();
        RST = 1'b0;
        ex_src[0] = 5'd2; ex_src[1] = 5'd2; mem_RegWr = 1; mem_wsel = 5'd2; mem_aluOut = 32'hC0DE;
        ex_MemRead = 1; ex_RegWr = 1; ex_wsel = 5'd6; id_src[0] = 5'd6;
        for (int k = 0; k < 18; k++) cycle();

        // Reset asserted while a value is held: nothing survives
        idle();
        ex_src[0] = 5'd7; wr_RegWr = 1; wr_wsel = 5'd7; writeback = 32'h1234; ex_stall = 1;
        cycle();
        async_reset();
        ex_src[1] = 5'd3; mem_RegWr = 1; mem_wsel = 5'd3; mem_aluOut = 32'hBEEF;
        cycle();
        RST = 1'b0;
        wr_wsel = 5'd9; writeback = 32'hFFFF;
        cycle();
        cycle();

        // Random traffic over a small register window
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NS; i++) begin
                ex_src[i] = AW'($urandom_range(0, 3));
                id_src[i] = AW'($urandom_range(0, 3));
            end
            ex_RegWr     = 1'($urandom_range(0, 1));
            ex_MemRead   = 1'($urandom_range(0, 1));
            ex_wsel      = AW'($urandom_range(0, 3));
            mem_RegWr    = 1'($urandom_range(0, 1));
            mem_MemToReg = ($urandom_range(0, 3) == 0);
            mem_wsel     = AW'($urandom_range(0, 3));
            mem_aluOut   = $urandom;
            wr_RegWr     = 1'($urandom_range(0, 1));
            wr_wsel      = AW'($urandom_range(0, 3));
            writeback    = $urandom;
            ex_stall     = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter REG_AW, 5, register index width; index 0 is the hardwired zero register.
REQ-003 Parameter NSRC, 2, number of EX-stage source operands forwarded independently.
REQ-004 Parameter CNT_W, 16, width of the saturating statistics counters.
REQ-005 CLK  in  1  sole clock, rising edge; RST  in  1  asynchronous, active-high reset.
REQ-006 ex_src[NSRC]  in  REG_AW each  source indices of the instruction in EX.
REQ-007 id_src[NSRC]  in  REG_AW each  source indices of the instruction in ID.
REQ-008 ex_RegWr, ex_MemRead  in  1 each; ex_wsel  in  REG_AW  destination of the instruction in EX.
REQ-009 mem_RegWr, mem_MemToReg  in  1 each; mem_wsel  in  REG_AW; mem_aluOut  in  DATA_W.
REQ-010 wr_RegWr  in  1; wr_wsel  in  REG_AW; writeback  in  DATA_W  final WB value.
REQ-011 ex_stall  in  1  EX/MEM/WB hold (memory wait); flush  in  1  EX contents squashed.
REQ-012 override[NSRC]  out  1 each; new_rdat[NSRC]  out  DATA_W each  forwarded operand.
REQ-013 lu_stall  out  1  hold PC/ID, insert bubble into EX.
REQ-014 fwd_cnt, lu_cnt  out  CNT_W each  saturating forward-event and load-use-stall counts.

Function
REQ-015 Per source i, with ex_src[i]==0: override[i]=0 and new_rdat[i]=0 in all states.
REQ-016 Priority per source: MEM (mem_RegWr && !mem_MemToReg && mem_wsel==ex_src[i]) > HELD value > WB (wr_RegWr && wr_wsel==ex_src[i]) > none.
REQ-017 MEM match supplies mem_aluOut; WB match supplies writeback; none gives override 0, new_rdat 0.
REQ-018 A MEM-stage load (mem_MemToReg=1) never forwards from MEM; the operand is covered by lu_stall or by WB.
REQ-019 Forwarding outputs are combinational from inputs and hold registers: zero-cycle latency.
REQ-020 Per-source hold FSM, states EMPTY and HELD; reset state EMPTY.
REQ-021 EMPTY->HELD on a rising edge with ex_stall=1, no MEM match, WB match: hold_data[i] captures writeback.
REQ-022 HELD->EMPTY on any edge with ex_stall=0 or flush=1; otherwise stay HELD with hold_data unchanged.
REQ-023 flush=1 forces every hold FSM to EMPTY on that edge, overriding capture.
REQ-024 lu_stall=1 when ex_MemRead && ex_RegWr && ex_wsel!=0 && ex_wsel==id_src[j] for any j; otherwise 0.
REQ-025 lu_stall is forced 0 while ex_stall=1 or flush=1; the pipeline freeze covers the hazard.
REQ-026 fwd_cnt increments by the number of sources with override=1 on each edge with ex_stall=0; saturates at all-ones.
REQ-027 lu_cnt increments by 1 on each edge with lu_stall=1; saturates at all-ones.
REQ-028 Counters never wrap; both sources forwarding in one cycle adds 2, clipped at saturation.

Reset
REQ-029 RST=1 asynchronously sets all hold FSMs EMPTY, hold_data 0, fwd_cnt 0, lu_cnt 0.
REQ-030 During reset, override=0 and lu_stall=0, with new_rdat driven by the combinational MEM/WB path only.
REQ-031 Reset released mid-stall starts from EMPTY; no held value survives reset.

Structure
REQ-032 Shared package fwd_pkg holds the fwd_sel_t enum (NONE, MEM, HELD, WB) and the hold_state_t enum (EMPTY, HELD).
REQ-033 One sub-module, fwd_src_slice, holds one source's select, hold FSM and hold register.
REQ-034 The top generates NSRC slices and holds the load-use detect and the counters.

Verification
REQ-035 ex_src[0]=3, mem_RegWr=1, mem_wsel=3, mem_aluOut=0xA5, wr_wsel=3, writeback=0x11 -> override[0]=1, new_rdat[0]=0xA5.
REQ-036 ex_src[1]=0, all stage wsel=0, RegWr=1 -> override[1]=0, new_rdat[1]=0.
REQ-037 WB match on r7 = 0x1234, ex_stall=1 for 3 cycles, WB then changes to r9 = 0xFFFF -> new_rdat=0x1234 and override=1 all 3 cycles; ex_stall=0 -> EMPTY next edge.
REQ-038 ex_MemRead=1, ex_wsel=4, id_src[1]=4 -> lu_stall=1 and lu_cnt+1; same stimulus with ex_stall=1 -> lu_stall=0.
REQ-039 HELD state, then flush=1 with ex_stall=1 -> EMPTY next edge, override from the hold path drops.
REQ-040 fwd_cnt preset near all-ones, both sources forward -> fwd_cnt=all-ones, no wrap; RST pulse mid-run -> all counters 0 asynchronously.
